// File: rtl/bsg_comm_link_token_gen.sv
// Receive-side credit-to-token generator: decimates dequeue credits into paced
// rise/fall pulses on the token line driven back to the channel transmitter.
module bsg_comm_link_token_gen #(
    parameter int lg_input_fifo_depth_p           = 5,
    parameter int lg_credit_to_token_decimation_p = 3,
    parameter int min_half_period_p               = 2
) (
    input  logic                                                          clk_i,
    input  logic                                                          reset_n_i,
    input  logic                                                          enable_i,
    input  logic                                                          deq_i,
    output logic                                                          token_o,
    output logic [lg_input_fifo_depth_p-lg_credit_to_token_decimation_p:0] pending_tokens_o,
    output logic                                                          overflow_o
);

    localparam int pw_lp = lg_input_fifo_depth_p - lg_credit_to_token_decimation_p + 1;
    localparam int hw_lp = (min_half_period_p > 1) ? $clog2(min_half_period_p) : 1;

    localparam logic [pw_lp-1:0] pmax_lp      = pw_lp'(1) << (pw_lp - 1);
    localparam logic [hw_lp-1:0] hold_init_lp = hw_lp'(min_half_period_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e           state_r;
    logic [hw_lp-1:0] hold_r;

    logic deq_en;
    logic earn;
    logic launch;
    logic pending_nz;
    logic at_pmax;
    logic hold_done;

    assign deq_en     = enable_i & deq_i;
    assign pending_nz = (pending_tokens_o != '0);
    assign at_pmax    = (pending_tokens_o == pmax_lp);
    assign hold_done  = (hold_r == '0);

    // A launch consumes one pending token; the FSM and the pending counter
    // must agree on exactly when that happens.
    assign launch = enable_i & pending_nz &
                    ((state_r == IDLE) | ((state_r == LOW) & hold_done));

    // Credit decimation: the wrap of the counter is the earn event.
    generate
        if (lg_credit_to_token_decimation_p > 0) begin : g_credit
            logic [lg_credit_to_token_decimation_p-1:0] credit_r;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    credit_r <= '0;
                end else if (!enable_i) begin
                    credit_r <= '0;
                end else if (deq_en) begin
                    credit_r <= credit_r + lg_credit_to_token_decimation_p'(1);
                end
            end

            assign earn = deq_en & (&credit_r);
        end else begin : g_no_credit
            assign earn = deq_en;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_tokens_o <= '0;
        end else if (!enable_i) begin
            pending_tokens_o <= '0;
        end else begin
            case ({earn, launch})
                2'b10: if (!at_pmax) pending_tokens_o <= pending_tokens_o + pw_lp'(1);
                2'b01: pending_tokens_o <= pending_tokens_o - pw_lp'(1);
                default: pending_tokens_o <= pending_tokens_o;
            endcase
        end
    end

    // Sticky; survives the enable flush so firmware can still see it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overflow_o <= 1'b0;
        end else if (earn & at_pmax & ~launch) begin
            overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            token_o <= 1'b0;
            hold_r  <= '0;
        end else if (!enable_i) begin
            state_r <= IDLE;
            token_o <= 1'b0;
            hold_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch) begin
                        token_o <= 1'b1;
                        hold_r  <= hold_init_lp;
                        state_r <= HIGH;
                    end
                end
                HIGH: begin
                    if (hold_done) begin
                        token_o <= 1'b0;
                        hold_r  <= hold_init_lp;
                        state_r <= LOW;
                    end else begin
                        hold_r <= hold_r - hw_lp'(1);
                    end
                end
                LOW: begin
                    if (hold_done) begin
                        if (launch) begin
                            token_o <= 1'b1;
                            hold_r  <= hold_init_lp;
                            state_r <= HIGH;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        hold_r <= hold_r - hw_lp'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    token_o <= 1'b0;
                    hold_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_comm_link_token_gen.sv
// Bench: default instance plus a small-FIFO / slow-pulse instance, both driven
// identically and compared each cycle against a launch-time reference model.
module tb_bsg_comm_link_token_gen;

    logic       clk, reset_n, enable, deq;
    logic       tok0, ovf0, tok1, ovf1;
    logic [2:0] pend0;
    logic [1:0] pend1;

    bsg_comm_link_token_gen u0 (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .deq_i(deq),
        .token_o(tok0), .pending_tokens_o(pend0), .overflow_o(ovf0)
    );

    bsg_comm_link_token_gen #(
        .lg_input_fifo_depth_p(4),
        .lg_credit_to_token_decimation_p(3),
        .min_half_period_p(16)
    ) u1 (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .deq_i(deq),
        .token_o(tok1), .pending_tokens_o(pend1), .overflow_o(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: tokens are launched no sooner than 2*H cycles after the previous
    // launch; the line is high for the H cycles following a launch.
    typedef struct {
        int credits;
        int pending;
        bit ovf;
        bit have;
        int last;
    } mdl_t;

    mdl_t m0, m1;
    int   cyc;
    int   total, bad;
    logic s_tok0, s_tok1, s_ovf0, s_ovf1;
    int   s_pend0, s_pend1;

    function automatic mdl_t mstep(mdl_t m, bit en, bit d, int k, int pmax, int h, int c);
        mdl_t n = m;
        bit   earn;
        bit   launch;
        if (!en) begin
            n.credits = 0;
            n.pending = 0;
            n.have    = 0;
            return n;
        end
        earn      = d && (m.credits == (1 << k) - 1);
        n.credits = d ? (m.credits + 1) % (1 << k) : m.credits;
        launch    = (m.pending > 0) && (!m.have || (c - m.last) >= 2 * h);
        n.pending = m.pending + (earn ? 1 : 0) - (launch ? 1 : 0);
        if (n.pending > pmax) begin
            n.pending = pmax;
            n.ovf     = 1;
        end
        if (launch) begin
            n.have = 1;
            n.last = c;
        end
        return n;
    endfunction

    function automatic bit mtok(mdl_t m, int h, int c);
        return m.have && (c - m.last) >= 1 && (c - m.last) <= h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit en, input bit d);
        @(negedge clk);
        s_tok0 = tok0; s_ovf0 = ovf0; s_pend0 = int'(pend0);
        s_tok1 = tok1; s_ovf1 = ovf1; s_pend1 = int'(pend1);
        chk("tok0",  tok0,  mtok(m0, 2, cyc));
        chk("pend0", pend0, m0.pending);
        chk("ovf0",  ovf0,  m0.ovf);
        chk("tok1",  tok1,  mtok(m1, 16, cyc));
        chk("pend1", pend1, m1.pending);
        chk("ovf1",  ovf1,  m1.ovf);
        enable = en;
        deq    = d;
        m0 = mstep(m0, en, d, 3, 4, 2, cyc);
        m1 = mstep(m1, en, d, 3, 2, 16, cyc);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        deq     = 1'b0;
        #1;
        chk("rst_tok0",  tok0,  0);
        chk("rst_pend0", pend0, 0);
        chk("rst_ovf0",  ovf0,  0);
        chk("rst_tok1",  tok1,  0);
        chk("rst_ovf1",  ovf1,  0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m0  = '{default: 0};
        m1  = '{default: 0};
        cyc = 0;
    endtask

    int rises0, rises1, maxp;
    int rise_t[8];
    logic prev0, prev1;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        deq     = 1'b0;
        total   = 0;
        bad     = 0;
        m0  = '{default: 0};
        m1  = '{default: 0};
        cyc = 0;

        // single token from 8 credits
        do_reset();
        for (int t = 0; t < 14; t++) begin
            step(1, t < 8);
            if (t == 8) chk("s1_pend8", s_pend0, 1);
            if (t == 9) begin
                chk("s1_pend9", s_pend0, 0);
                chk("s1_tok9", s_tok0, 1);
            end
            if (t == 10) chk("s1_tok10", s_tok0, 1);
            if (t == 11) chk("s1_tok11", s_tok0, 0);
        end

        // asynchronous reset while the line is high
        do_reset();
        for (int t = 0; t < 10; t++) step(1, t < 8);
        chk("async_pre_tok0", s_tok0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_tok0", tok0, 0);
        chk("async_tok1", tok1, 0);

        // continuous dequeue, default config: four evenly spaced rises
        do_reset();
        rises0 = 0; maxp = 0; prev0 = 1'b0;
        for (int t = 0; t < 36; t++) begin
            step(1, t < 32);
            if (s_tok0 && !prev0 && rises0 < 8) begin
                rise_t[rises0] = t;
                rises0++;
            end
            prev0 = s_tok0;
            if (s_pend0 > maxp) maxp = s_pend0;
        end
        chk("s3_rises", rises0, 4);
        for (int i = 0; i < 4; i++) chk("s3_rise_t", rise_t[i], 9 + 8 * i);
        chk("s3_maxpend_le1", maxp <= 1, 1);
        chk("s3_ovf", s_ovf0, 0);

        // saturation and overflow on the small-FIFO instance
        do_reset();
        for (int t = 0; t < 45; t++) begin
            step(1, 1);
            if (t == 16) chk("s4_pend16", s_pend1, 1);
            if (t == 24) chk("s4_pend24", s_pend1, 2);
            if (t == 31) chk("s4_ovf31", s_ovf1, 0);
            if (t == 32) begin
                chk("s4_ovf32", s_ovf1, 1);
                chk("s4_pend32", s_pend1, 2);
            end
            if (t == 40) chk("s4_tok40", s_tok1, 0);
            if (t == 41) chk("s4_tok41", s_tok1, 1);
        end

        // earn coinciding with a LOW->HIGH launch
        do_reset();
        for (int t = 0; t < 45; t++) begin
            step(1, (t < 8) || (t >= 23 && t <= 30) || (t >= 33 && t <= 40));
            if (t == 40) begin
                chk("s5_pend40", s_pend1, 1);
                chk("s5_tok40", s_tok1, 0);
            end
            if (t == 41) begin
                chk("s5_pend41", s_pend1, 1);
                chk("s5_tok41", s_tok1, 1);
            end
        end

        // enable flush mid-pulse, ignored credits, then one fresh token
        do_reset();
        rises0 = 0; rises1 = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int t = 0; t < 42; t++) begin
            step(!(t >= 10 && t < 20), t < 28);
            if (t == 11) begin
                chk("s6_tok0", s_tok0, 0);
                chk("s6_tok1", s_tok1, 0);
                chk("s6_pend0", s_pend0, 0);
            end
            if (t >= 12) begin
                if (s_tok0 && !prev0) rises0++;
                if (s_tok1 && !prev1) rises1++;
            end
            prev0 = s_tok0;
            prev1 = s_tok1;
        end
        chk("s6_rises0", rises0, 1);
        chk("s6_rises1", rises1, 1);

        // randomized traffic with occasional flushes and resets
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            dens = $urandom_range(1, 4);
            for (int t = 0; t < 500; t++) begin
                if ($urandom_range(0, 399) == 0) do_reset();
                step($urandom_range(0, 29) != 0, $urandom_range(0, 4) < dens);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
